// File: rtl/core_if_bpu_pkg.sv
// Shared constants and helpers for the IF-stage branch prediction unit.
package core_if_bpu_pkg;

    localparam int unsigned CORE_XLEN     = 32;
    localparam int unsigned DEF_BHT_DEPTH = 64;
    localparam int unsigned DEF_RAS_DEPTH = 4;
    localparam logic [1:0]  DEF_BHT_INIT  = 2'b01;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // x1 (ra) and x5 (t0) are the ABI link registers
    function automatic logic is_link(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

endpackage

// File: rtl/core_if_ras.sv
// Return address stack: circular storage with top-of-stack pointer and occupancy count.
module core_if_ras
    import core_if_bpu_pkg::*;
#(
    parameter int unsigned RAS_DEPTH = DEF_RAS_DEPTH,
    parameter int unsigned XLEN      = CORE_XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic            flush,
    input  logic [XLEN-1:0] push_val,
    output logic [XLEN-1:0] top,
    output logic            empty
);

    localparam int unsigned AW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [XLEN-1:0] entries [RAS_DEPTH];
    logic [AW-1:0]   tos, tos_n, wr_idx;
    logic [CW-1:0]   count, count_n;
    logic            wr_en;

    assign top   = entries[tos];
    assign empty = (count == CW'(0));

    // Coroutine swap on a non-empty stack rewrites the top in place
    always_comb begin
        tos_n   = tos;
        count_n = count;
        wr_en   = 1'b0;
        wr_idx  = tos + AW'(1);
        if (flush) begin
            tos_n   = AW'(0);
            count_n = CW'(0);
        end else if (push && pop) begin
            wr_en = 1'b1;
            if (count == CW'(0)) begin
                tos_n   = tos + AW'(1);
                count_n = CW'(1);
            end else begin
                wr_idx = tos;
            end
        end else if (push) begin
            wr_en = 1'b1;
            tos_n = tos + AW'(1);
            if (count != CW'(RAS_DEPTH)) begin
                count_n = count + CW'(1);
            end
        end else if (pop && (count != CW'(0))) begin
            tos_n   = tos - AW'(1);
            count_n = count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tos   <= AW'(0);
            count <= CW'(0);
            for (int i = 0; i < RAS_DEPTH; i++) begin
                entries[i] <= XLEN'(0);
            end
        end else begin
            tos   <= tos_n;
            count <= count_n;
            if (wr_en) begin
                entries[wr_idx] <= push_val;
            end
        end
    end

endmodule

// File: rtl/core_if_bpu.sv
// IF-stage branch predictor: pre-decode, immediate extraction, 2-bit BHT and RAS-based return prediction.
module core_if_bpu
    import core_if_bpu_pkg::*;
#(
    parameter int unsigned BHT_DEPTH = DEF_BHT_DEPTH,
    parameter int unsigned RAS_DEPTH = DEF_RAS_DEPTH,
    parameter logic [1:0]  BHT_INIT  = DEF_BHT_INIT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_valid,
    input  logic [CORE_XLEN-1:0] i_pc,
    input  logic [31:0]          i_inst,
    input  logic                 i_flush,
    input  logic                 upd_valid,
    input  logic [CORE_XLEN-1:0] upd_pc,
    input  logic                 upd_taken,
    output logic                 o_is_jal,
    output logic                 o_is_jalr,
    output logic                 o_is_branch,
    output logic [CORE_XLEN-1:0] o_bj_imm,
    output logic                 o_pred_taken,
    output logic [CORE_XLEN-1:0] o_pred_target
);

    localparam int unsigned XLEN   = CORE_XLEN;
    localparam int unsigned BHT_IW = $clog2(BHT_DEPTH);

    logic [1:0]        bht [BHT_DEPTH];
    logic [BHT_IW-1:0] look_idx, upd_idx;
    logic [XLEN-1:0]   imm_j, imm_i, imm_b, ras_top;
    logic [4:0]        rd, rs1;
    logic              ras_empty, ras_push, ras_pop;
    logic              unused_upd_pc;

    assign rd  = i_inst[11:7];
    assign rs1 = i_inst[19:15];

    assign imm_j = {{(XLEN-21){i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
    assign imm_i = {{(XLEN-12){i_inst[31]}}, i_inst[31:20]};
    assign imm_b = {{(XLEN-13){i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};

    assign o_is_jal    = i_valid && (i_inst[6:0] == OPC_JAL);
    assign o_is_jalr   = i_valid && (i_inst[6:0] == OPC_JALR);
    assign o_is_branch = i_valid && (i_inst[6:0] == OPC_BRANCH);

    assign look_idx      = i_pc[BHT_IW+1:2];
    assign upd_idx       = upd_pc[BHT_IW+1:2];
    assign unused_upd_pc = ^{upd_pc[XLEN-1:BHT_IW+2], upd_pc[1:0]};

    // rd==rs1 on a link register is a plain call, not a return
    assign ras_push = (o_is_jal || o_is_jalr) && is_link(rd);
    assign ras_pop  = o_is_jalr && is_link(rs1) && !(is_link(rd) && (rs1 == rd));

    always_comb begin
        o_bj_imm      = XLEN'(0);
        o_pred_taken  = 1'b0;
        o_pred_target = XLEN'(0);
        if (o_is_jal) begin
            o_bj_imm      = imm_j;
            o_pred_taken  = 1'b1;
            o_pred_target = i_pc + imm_j;
        end else if (o_is_branch) begin
            o_bj_imm      = imm_b;
            o_pred_taken  = bht[look_idx][1];
            o_pred_target = i_pc + imm_b;
        end else if (o_is_jalr) begin
            o_bj_imm = imm_i;
            if (ras_pop && !ras_empty) begin
                o_pred_taken  = 1'b1;
                o_pred_target = ras_top;
            end
        end
    end

    // Saturating 2-bit counter training from EX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= BHT_INIT;
            end
        end else if (upd_valid) begin
            if (upd_taken) begin
                if (bht[upd_idx] != 2'b11) bht[upd_idx] <= bht[upd_idx] + 2'b01;
            end else begin
                if (bht[upd_idx] != 2'b00) bht[upd_idx] <= bht[upd_idx] - 2'b01;
            end
        end
    end

    core_if_ras #(
        .RAS_DEPTH (RAS_DEPTH),
        .XLEN      (XLEN)
    ) u_ras (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (ras_push),
        .pop      (ras_pop),
        .flush    (i_flush),
        .push_val (i_pc + XLEN'(4)),
        .top      (ras_top),
        .empty    (ras_empty)
    );

endmodule

// File: tb/tb_core_if_bpu.sv
// Directed self-checking bench for core_if_bpu: decode, BHT training, RAS call/return behaviour.
module tb_core_if_bpu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic [31:0] i_pc;
    logic [31:0] i_inst;
    logic        i_flush;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        o_is_jal, o_is_jalr, o_is_branch, o_pred_taken;
    logic [31:0] o_bj_imm, o_pred_target;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    core_if_bpu dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_valid       (i_valid),
        .i_pc          (i_pc),
        .i_inst        (i_inst),
        .i_flush       (i_flush),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_taken     (upd_taken),
        .o_is_jal      (o_is_jal),
        .o_is_jalr     (o_is_jalr),
        .o_is_branch   (o_is_branch),
        .o_bj_imm      (o_bj_imm),
        .o_pred_taken  (o_pred_taken),
        .o_pred_target (o_pred_target)
    );

    function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd0, rs1, 3'b000, rd, 7'b1100111};
    endfunction

    function automatic logic [31:0] enc_beq(input logic [12:0] imm);
        return {imm[12], imm[10:5], 5'd0, 5'd0, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] inst);
        i_valid = 1'b1;
        i_pc    = pc;
        i_inst  = inst;
        #1;
    endtask

    task automatic idle();
        i_valid   = 1'b0;
        i_flush   = 1'b0;
        upd_valid = 1'b0;
        i_pc      = 32'd0;
        i_inst    = 32'd0;
    endtask

    task automatic train(input logic [31:0] pc, input logic taken, input int n);
        i_valid   = 1'b0;
        upd_pc    = pc;
        upd_taken = taken;
        for (int k = 0; k < n; k++) begin
            upd_valid = 1'b1;
            tick();
        end
        upd_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        i_inst = enc_jal(5'd1, 21'h40);
        i_pc   = 32'h200;
        #1;
        checks++;
        if ({o_is_jal, o_is_jalr, o_is_branch, o_pred_taken} !== 4'b0000 ||
            o_bj_imm !== 32'd0 || o_pred_target !== 32'd0) begin
            errors++;
            $display("FAIL reset_idle_outputs got flags=%b imm=%h tgt=%h exp all zero",
                     {o_is_jal, o_is_jalr, o_is_branch, o_pred_taken}, o_bj_imm, o_pred_target);
        end
        idle();
    endtask

    task automatic test_branch_decode();
        fetch(32'h100, enc_beq(13'd16));
        checks++;
        if (o_is_branch !== 1'b1 || o_pred_taken !== 1'b0 || o_pred_target !== 32'h110 || o_bj_imm !== 32'd16) begin
            errors++;
            $display("FAIL beq_fwd got br=%b tk=%b tgt=%h imm=%h exp 1 0 00000110 00000010",
                     o_is_branch, o_pred_taken, o_pred_target, o_bj_imm);
        end
        fetch(32'h100, enc_beq(13'h1FF8));
        checks++;
        if (o_pred_target !== 32'h0F8 || o_bj_imm !== 32'hFFFF_FFF8) begin
            errors++;
            $display("FAIL beq_back got tgt=%h imm=%h exp 000000f8 fffffff8", o_pred_target, o_bj_imm);
        end
        idle();
    endtask

    task automatic test_bht_train();
        train(32'h100, 1'b1, 2);
        fetch(32'h100, enc_beq(13'd16));
        checks++;
        if (o_pred_taken !== 1'b1) begin
            errors++;
            $display("FAIL bht_two_taken got %b exp 1", o_pred_taken);
        end
        fetch(32'h104, enc_beq(13'd16));
        checks++;
        if (o_pred_taken !== 1'b0) begin
            errors++;
            $display("FAIL bht_other_idx got %b exp 0", o_pred_taken);
        end
        train(32'h100, 1'b1, 4);
        train(32'h100, 1'b0, 1);
        fetch(32'h100, enc_beq(13'd16));
        checks++;
        if (o_pred_taken !== 1'b1) begin
            errors++;
            $display("FAIL bht_sat_then_nt got %b exp 1", o_pred_taken);
        end
        train(32'h100, 1'b1, 1);
        train(32'h100, 1'b0, 2);
        fetch(32'h100, enc_beq(13'd16));
        checks++;
        if (o_pred_taken !== 1'b0) begin
            errors++;
            $display("FAIL bht_two_nt_from_11 got %b exp 0", o_pred_taken);
        end
        train(32'h100, 1'b0, 1);
        fetch(32'h100, enc_beq(13'd16));
        checks++;
        if (o_pred_taken !== 1'b0) begin
            errors++;
            $display("FAIL bht_three_nt got %b exp 0", o_pred_taken);
        end
        train(32'h100, 1'b0, 3);
        train(32'h100, 1'b1, 1);
        fetch(32'h100, enc_beq(13'd16));
        checks++;
        if (o_pred_taken !== 1'b0) begin
            errors++;
            $display("FAIL bht_sat_low got %b exp 0", o_pred_taken);
        end
        idle();
    endtask

    task automatic test_call_return();
        do_reset();
        fetch(32'h200, enc_jal(5'd1, 21'h40));
        checks++;
        if (o_is_jal !== 1'b1 || o_pred_taken !== 1'b1 || o_pred_target !== 32'h240 || o_bj_imm !== 32'h40) begin
            errors++;
            $display("FAIL jal_call got jal=%b tk=%b tgt=%h imm=%h exp 1 1 00000240 00000040",
                     o_is_jal, o_pred_taken, o_pred_target, o_bj_imm);
        end
        tick();
        fetch(32'h300, enc_jalr(5'd0, 5'd1));
        checks++;
        if (o_is_jalr !== 1'b1 || o_pred_taken !== 1'b1 || o_pred_target !== 32'h204 || o_bj_imm !== 32'd0) begin
            errors++;
            $display("FAIL ret_pop got jalr=%b tk=%b tgt=%h imm=%h exp 1 1 00000204 0",
                     o_is_jalr, o_pred_taken, o_pred_target, o_bj_imm);
        end
        tick();
        fetch(32'h304, enc_jalr(5'd0, 5'd1));
        checks++;
        if (o_pred_taken !== 1'b0 || o_pred_target !== 32'd0) begin
            errors++;
            $display("FAIL ret_empty got tk=%b tgt=%h exp 0 0", o_pred_taken, o_pred_target);
        end
        tick();
        idle();
    endtask

    task automatic test_ras_overflow();
        logic [31:0] exp_tgt [4];
        exp_tgt[0] = 32'h14;
        exp_tgt[1] = 32'h10;
        exp_tgt[2] = 32'h0C;
        exp_tgt[3] = 32'h08;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            fetch(32'(4 * k), enc_jal(5'd1, 21'h100));
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            fetch(32'h800, enc_jalr(5'd0, 5'd1));
            checks++;
            if (o_pred_taken !== 1'b1 || o_pred_target !== exp_tgt[k]) begin
                errors++;
                $display("FAIL ras_pop%0d got tk=%b tgt=%h exp 1 %h", k, o_pred_taken, o_pred_target, exp_tgt[k]);
            end
            tick();
        end
        fetch(32'h800, enc_jalr(5'd0, 5'd1));
        checks++;
        if (o_pred_taken !== 1'b0) begin
            errors++;
            $display("FAIL ras_pop4_empty got tk=%b exp 0", o_pred_taken);
        end
        tick();
        idle();
    endtask

    task automatic test_coroutine_flush();
        do_reset();
        fetch(32'h7C, enc_jal(5'd1, 21'h10));
        tick();
        fetch(32'h400, enc_jalr(5'd1, 5'd5));
        checks++;
        if (o_pred_taken !== 1'b1 || o_pred_target !== 32'h80) begin
            errors++;
            $display("FAIL coroutine got tk=%b tgt=%h exp 1 00000080", o_pred_taken, o_pred_target);
        end
        tick();
        fetch(32'h500, enc_jalr(5'd0, 5'd1));
        checks++;
        if (o_pred_taken !== 1'b1 || o_pred_target !== 32'h404) begin
            errors++;
            $display("FAIL coroutine_top got tk=%b tgt=%h exp 1 00000404", o_pred_taken, o_pred_target);
        end
        tick();
        fetch(32'h504, enc_jalr(5'd0, 5'd1));
        checks++;
        if (o_pred_taken !== 1'b0) begin
            errors++;
            $display("FAIL coroutine_count got tk=%b exp 0", o_pred_taken);
        end
        tick();
        fetch(32'h7C, enc_jal(5'd1, 21'h10));
        tick();
        fetch(32'h600, enc_jal(5'd1, 21'h10));
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        fetch(32'h700, enc_jalr(5'd0, 5'd1));
        checks++;
        if (o_pred_taken !== 1'b0 || o_pred_target !== 32'd0) begin
            errors++;
            $display("FAIL flush_empty got tk=%b tgt=%h exp 0 0", o_pred_taken, o_pred_target);
        end
        tick();
        idle();
    endtask

    task automatic test_same_cycle_and_reset();
        do_reset();
        fetch(32'h100, enc_beq(13'd16));
        upd_pc    = 32'h100;
        upd_taken = 1'b1;
        upd_valid = 1'b1;
        checks++;
        if (o_pred_taken !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_pre got tk=%b exp 0", o_pred_taken);
        end
        tick();
        upd_valid = 1'b0;
        #1;
        checks++;
        if (o_pred_taken !== 1'b1) begin
            errors++;
            $display("FAIL same_cycle_post got tk=%b exp 1", o_pred_taken);
        end
        train(32'h100, 1'b1, 1);
        fetch(32'h7C, enc_jal(5'd1, 21'h10));
        tick();
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        fetch(32'h100, enc_beq(13'd16));
        checks++;
        if (o_pred_taken !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_bht got tk=%b exp 0", o_pred_taken);
        end
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        fetch(32'h300, enc_jalr(5'd0, 5'd1));
        checks++;
        if (o_pred_taken !== 1'b0) begin
            errors++;
            $display("FAIL reset_ras_empty got tk=%b exp 0", o_pred_taken);
        end
        idle();
        train(32'h100, 1'b1, 1);
        fetch(32'h100, enc_beq(13'd16));
        checks++;
        if (o_pred_taken !== 1'b1) begin
            errors++;
            $display("FAIL reset_bht_init got tk=%b exp 1", o_pred_taken);
        end
        idle();
    endtask

    initial begin
        rst_n     = 1'b0;
        upd_pc    = 32'd0;
        upd_taken = 1'b0;
        idle();
        test_reset();
        test_branch_decode();
        test_bht_train();
        test_call_return();
        test_ras_overflow();
        test_coroutine_flush();
        test_same_cycle_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
